// File: rtl/mbe_op_initiator_if.sv
// rtl/mbe_op_initiator_if.sv - operand, multiplier, product and result channels of mbe_op_initiator
// master modport is the initiator side; slave is the source/multiplier/sink environment.
interface mbe_op_initiator_if #(
   parameter int WIDTH = 24
);
   logic                 op_valid;
   logic                 op_ready;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic                 mul_valid;
   logic                 mul_ready;
   logic [WIDTH-1:0]     mul_a;
   logic [WIDTH-1:0]     mul_b;
   logic                 prod_valid;
   logic                 prod_ready;
   logic [2*WIDTH-1:0]   prod_data;
   logic                 res_valid;
   logic                 res_ready;
   logic [2*WIDTH-1:0]   res_data;
   logic                 busy;
   logic                 timeout;
   logic                 mismatch;
   logic [15:0]          err_cnt;

   modport master (
      input  op_valid, op_a, op_b,
      output op_ready,
      output mul_valid, mul_a, mul_b,
      input  mul_ready,
      input  prod_valid, prod_data,
      output prod_ready,
      output res_valid, res_data,
      input  res_ready,
      output busy, timeout, mismatch, err_cnt
   );

   modport slave (
      output op_valid, op_a, op_b,
      input  op_ready,
      input  mul_valid, mul_a, mul_b,
      output mul_ready,
      output prod_valid, prod_data,
      input  prod_ready,
      input  res_valid, res_data,
      output res_ready,
      input  busy, timeout, mismatch, err_cnt
   );
endinterface

// File: rtl/mbe_op_initiator.sv
// rtl/mbe_op_initiator.sv - operand FIFO + single-transaction initiator for the MBE multiplier wrapper
// Optional product self-check enabled by defining MBE_OP_SELF_CHECK_EN.
module mbe_op_initiator #(
   parameter int WIDTH       = 24,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             rst,
   mbe_op_initiator_if.master bus
);

   localparam int AW     = $clog2(DEPTH);
   localparam int TW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam bit TMO_EN = (TIMEOUT_CYC != 0);

   typedef enum logic [1:0] {IDLE, ISSUE, AWAIT, DELIVER} state_t;

   state_t               state;
   state_t               state_nxt;

   logic [WIDTH-1:0]     fifo_a [DEPTH];
   logic [WIDTH-1:0]     fifo_b [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 capture;
   logic                 abort;

   logic [TW-1:0]        tmo_cnt;
   logic                 tmo_hit;

   logic [WIDTH-1:0]     mul_a_q;
   logic [WIDTH-1:0]     mul_b_q;
   logic [2*WIDTH-1:0]   res_data_q;
   logic                 timeout_q;

   assign full          = (count == (AW+1)'(DEPTH));
   assign empty         = (count == '0);
   assign push          = bus.op_valid && !full;
   assign bus.op_ready  = !full;

   // Handshakes and state-derived valids are all decoded from the registered state.
   assign bus.mul_valid  = (state == ISSUE);
   assign bus.prod_ready = (state == AWAIT);
   assign bus.res_valid  = (state == DELIVER);
   assign bus.mul_a      = mul_a_q;
   assign bus.mul_b      = mul_b_q;
   assign bus.res_data   = res_data_q;
   assign bus.timeout    = timeout_q;
   assign bus.busy       = (state != IDLE) || !empty;

   assign tmo_hit = TMO_EN && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A handshake in the final allowed cycle is checked before the timeout.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      capture   = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.mul_ready) begin
               state_nxt = AWAIT;
            end else if (tmo_hit) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         AWAIT: begin
            if (bus.prod_valid) begin
               capture   = 1'b1;
               state_nxt = DELIVER;
            end else if (tmo_hit) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         DELIVER: begin
            if (bus.res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_a[wr_ptr] <= bus.op_a;
         fifo_b[wr_ptr] <= bus.op_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // tmo_cnt saturates so the budget covers ISSUE and AWAIT combined without wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         res_data_q <= '0;
         tmo_cnt    <= '0;
         timeout_q  <= 1'b0;
      end else begin
         if (pop) begin
            mul_a_q <= fifo_a[rd_ptr];
            mul_b_q <= fifo_b[rd_ptr];
            tmo_cnt <= '0;
         end else if (((state == ISSUE) || (state == AWAIT)) && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (capture) begin
            res_data_q <= bus.prod_data;
         end
         if (abort) begin
            timeout_q <= 1'b1;
         end
      end
   end

`ifdef MBE_OP_SELF_CHECK_EN
   logic [2*WIDTH-1:0]   expect_prod;
   logic                 bad_prod;
   logic                 mismatch_q;
   logic [15:0]          err_q;

   assign expect_prod = {{WIDTH{1'b0}}, mul_a_q} * {{WIDTH{1'b0}}, mul_b_q};
   assign bad_prod    = capture && (bus.prod_data != expect_prod);

   always_ff @(posedge clk) begin
      if (rst) begin
         mismatch_q <= 1'b0;
         err_q      <= '0;
      end else begin
         mismatch_q <= bad_prod;
         if (bad_prod && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 1'b1;
         end
      end
   end

   assign bus.mismatch = mismatch_q;
   assign bus.err_cnt  = err_q;
`else
   assign bus.mismatch = 1'b0;
   assign bus.err_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_mbe_op_initiator.sv
// tb/tb_mbe_op_initiator.sv - directed table-driven bench for mbe_op_initiator
module tb_mbe_op_initiator;
   localparam int W = 24;

`ifdef MBE_OP_SELF_CHECK_EN
   localparam logic SC = 1'b1;
`else
   localparam logic SC = 1'b0;
`endif

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mbe_op_initiator_if #(.WIDTH(W)) mif ();
   mbe_op_initiator_if #(.WIDTH(W)) tif ();

   mbe_op_initiator #(.WIDTH(W), .DEPTH(4), .TIMEOUT_CYC(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif.master)
   );

   mbe_op_initiator #(.WIDTH(W), .DEPTH(4), .TIMEOUT_CYC(8)) dut_t (
      .clk (clk),
      .rst (rst),
      .bus (tif.master)
   );

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
      bit ok;
      ok = 1'b0;
      mif.op_valid = 1'b1;
      mif.op_a     = a;
      mif.op_b     = b;
      for (int i = 0; i < 50 && !ok; i++) begin
         ok = mif.op_ready;
         tick();
      end
      mif.op_valid = 1'b0;
      chk({name, "_accept"}, ok, 1);
   endtask

   task automatic serve(input logic [2*W-1:0] exp, input bit force_en, input logic [2*W-1:0] fval,
                        input int hold, input string name);
      logic [2*W-1:0] p;
      bit seen;
      seen = 1'b0;
      mif.mul_ready = 1'b1;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (mif.mul_valid) seen = 1'b1;
         else tick();
      end
      chk({name, "_issue"}, seen, 1);
      p = {{W{1'b0}}, mif.mul_a} * {{W{1'b0}}, mif.mul_b};
      tick();
      mif.mul_ready = 1'b0;
      chk({name, "_prod_ready"}, mif.prod_ready, 1);
      chk({name, "_mul_valid_drop"}, mif.mul_valid, 0);
      mif.prod_valid = 1'b1;
      mif.prod_data  = force_en ? fval : p;
      tick();
      mif.prod_valid = 1'b0;
      chk({name, "_res_valid"}, mif.res_valid, 1);
      chk({name, "_res_data"}, mif.res_data, exp);
      chk({name, "_mismatch"}, mif.mismatch, force_en ? SC : 1'b0);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({name, "_hold_valid"}, mif.res_valid, 1);
         chk({name, "_hold_data"}, mif.res_data, exp);
         chk({name, "_hold_no_issue"}, mif.mul_valid, 0);
      end
      mif.res_ready = 1'b1;
      tick();
      mif.res_ready = 1'b0;
      chk({name, "_res_done"}, mif.res_valid, 0);
      chk({name, "_mismatch_end"}, mif.mismatch, 0);
   endtask

   vec_t vecs [5];
   vec_t qvec [5];

   initial begin
      vecs[0] = '{a: 24'd3,       b: 24'd5,       p: 48'd15};
      vecs[1] = '{a: 24'hFFFFFF,  b: 24'hFFFFFF,  p: 48'hFFFFFE000001};
      vecs[2] = '{a: 24'd0,       b: 24'd123,     p: 48'd0};
      vecs[3] = '{a: 24'd1000,    b: 24'd1000,    p: 48'd1000000};
      vecs[4] = '{a: 24'h800000,  b: 24'd2,       p: 48'h1000000};
      qvec[0] = '{a: 24'd1,  b: 24'd1,  p: 48'd1};
      qvec[1] = '{a: 24'd2,  b: 24'd3,  p: 48'd6};
      qvec[2] = '{a: 24'd4,  b: 24'd5,  p: 48'd20};
      qvec[3] = '{a: 24'd6,  b: 24'd7,  p: 48'd42};
      qvec[4] = '{a: 24'd10, b: 24'd10, p: 48'd100};

      mif.op_valid = 0; mif.op_a = 0; mif.op_b = 0; mif.mul_ready = 0;
      mif.prod_valid = 0; mif.prod_data = 0; mif.res_ready = 0;
      tif.op_valid = 0; tif.op_a = 0; tif.op_b = 0; tif.mul_ready = 0;
      tif.prod_valid = 0; tif.prod_data = 0; tif.res_ready = 0;

      // reset held three cycles
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_mul_valid", mif.mul_valid, 0);
      chk("rst_res_valid", mif.res_valid, 0);
      chk("rst_prod_ready", mif.prod_ready, 0);
      chk("rst_op_ready", mif.op_ready, 1);
      chk("rst_busy", mif.busy, 0);
      chk("rst_timeout", mif.timeout, 0);
      chk("rst_err_cnt", mif.err_cnt, 0);
      chk("rst_res_data", mif.res_data, 0);

      // single transaction latency then table vectors
      push(vecs[0].a, vecs[0].b, "lat");
      chk("lat_not_yet", mif.mul_valid, 0);
      chk("lat_busy", mif.busy, 1);
      tick();
      chk("lat_issue", mif.mul_valid, 1);
      serve(vecs[0].p, 1'b0, 0, 0, "v0");
      for (int i = 1; i < 5; i++) begin
         push(vecs[i].a, vecs[i].b, $sformatf("v%0d", i));
         serve(vecs[i].p, 1'b0, 0, 0, $sformatf("v%0d", i));
      end
      chk("retain_mul_a", mif.mul_a, vecs[4].a);
      chk("retain_mul_b", mif.mul_b, vecs[4].b);
      chk("idle_busy", mif.busy, 0);

      // fill: one issued plus four buffered, sixth refused
      for (int i = 0; i < 5; i++) push(qvec[i].a, qvec[i].b, $sformatf("q%0d", i));
      mif.op_valid = 1'b1;
      mif.op_a = 24'd99;
      mif.op_b = 24'd99;
      for (int i = 0; i < 3; i++) begin
         chk("full_op_ready", mif.op_ready, 0);
         tick();
      end
      mif.op_valid = 1'b0;
      for (int i = 0; i < 5; i++) serve(qvec[i].p, 1'b0, 0, 0, $sformatf("qs%0d", i));
      tick();
      chk("drain_busy", mif.busy, 0);

      // result stall with a second op waiting in the FIFO
      push(24'd7, 24'd9, "st0");
      push(24'd2, 24'd3, "st1");
      serve(48'd63, 1'b0, 0, 10, "stall");
      serve(48'd6, 1'b0, 0, 0, "after_stall");

      // handshake on the final timeout cycle wins
      tif.op_valid = 1'b1; tif.op_a = 24'd4; tif.op_b = 24'd4;
      tick();
      tif.op_valid = 1'b0;
      chk("t_lat0", tif.mul_valid, 0);
      tick();
      chk("t_issue", tif.mul_valid, 1);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("t_wait_timeout", tif.timeout, 0);
      end
      tif.mul_ready = 1'b1;
      tick();
      tif.mul_ready = 1'b0;
      chk("t_last_hs_timeout", tif.timeout, 0);
      chk("t_last_hs_prod_ready", tif.prod_ready, 1);
      tif.prod_valid = 1'b1; tif.prod_data = 48'd16;
      tick();
      tif.prod_valid = 1'b0;
      chk("t_last_res_valid", tif.res_valid, 1);
      chk("t_last_res_data", tif.res_data, 48'd16);
      tif.res_ready = 1'b1;
      tick();
      tif.res_ready = 1'b0;

      // real timeout: eight cycles after mul_valid rises
      tif.op_valid = 1'b1; tif.op_a = 24'd5; tif.op_b = 24'd6;
      tick();
      tif.op_valid = 1'b0;
      tick();
      chk("t2_issue", tif.mul_valid, 1);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("t2_pre_timeout", tif.timeout, 0);
      end
      tick();
      chk("t2_timeout", tif.timeout, 1);
      chk("t2_mul_valid", tif.mul_valid, 0);
      chk("t2_no_result", tif.res_valid, 0);
      tif.op_valid = 1'b1; tif.op_a = 24'd7; tif.op_b = 24'd8;
      tick();
      tif.op_valid = 1'b0;
      tick();
      chk("t3_issue", tif.mul_valid, 1);
      chk("t3_mul_a", tif.mul_a, 24'd7);
      tif.mul_ready = 1'b1;
      tick();
      tif.mul_ready = 1'b0;
      tif.prod_valid = 1'b1; tif.prod_data = 48'd56;
      tick();
      tif.prod_valid = 1'b0;
      chk("t3_res_data", tif.res_data, 48'd56);
      chk("t3_sticky", tif.timeout, 1);
      tif.res_ready = 1'b1;
      tick();
      tif.res_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t_rst_clear", tif.timeout, 0);

      // forced wrong product
      push(24'd2, 24'd2, "sc");
      serve(48'h5, 1'b1, 48'h5, 0, "sc");
      chk("sc_err_cnt", mif.err_cnt, SC ? 48'd1 : 48'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
